// File: rtl/sparc_ffu_vis_issue_if.sv
// Handshake and data bundle between FFU control/FRF/VIS datapath/writeback and the VIS issue stage.
// slave = the issue stage, master = everything around it.
interface sparc_ffu_vis_issue_if #(
    parameter int DW   = 64,
    parameter int TIDW = 2
);
    logic            ctl_vis_valid;
    logic            vis_ctl_ready;
    logic [8:0]      ctl_vis_opf;
    logic [TIDW-1:0] ctl_vis_tid;
    logic [4:0]      ctl_vis_rd;
    logic [DW-1:0]   frf_vis_rs1;
    logic [DW-1:0]   frf_vis_rs2;
    logic            ctl_vis_kill_e;
    logic            gsr_wr_en;
    logic [2:0]      gsr_wr_align;
    logic [2:0]      vis_gsr_align;
    logic [DW-1:0]   dp_vis_rs1;
    logic [DW-1:0]   dp_vis_rs2;
    logic            ctl_vis_sel_add;
    logic            ctl_vis_sel_log;
    logic            ctl_vis_sel_align;
    logic            ctl_vis_add32;
    logic            ctl_vis_subtract;
    logic            ctl_vis_cin;
    logic            ctl_vis_align0;
    logic            ctl_vis_align2;
    logic            ctl_vis_align4;
    logic            ctl_vis_align6;
    logic            ctl_vis_align_odd;
    logic            ctl_vis_log_sel_nor;
    logic            ctl_vis_log_sel_nand;
    logic            ctl_vis_log_sel_xor;
    logic            ctl_vis_log_sel_pass;
    logic            ctl_vis_log_invert_rs1;
    logic            ctl_vis_log_invert_rs2;
    logic            ctl_vis_log_constant;
    logic            ctl_vis_log_pass_const;
    logic            ctl_vis_log_pass_rs1;
    logic            ctl_vis_log_pass_rs2;
    logic [DW-1:0]   vis_dp_rd_data;
    logic            vis_wb_valid;
    logic            wb_vis_ready;
    logic [DW-1:0]   vis_wb_data;
    logic [TIDW-1:0] vis_wb_tid;
    logic [4:0]      vis_wb_rd;
    logic            vis_wb_illegal;

    modport slave (
        input  ctl_vis_valid, ctl_vis_opf, ctl_vis_tid, ctl_vis_rd, frf_vis_rs1, frf_vis_rs2,
               ctl_vis_kill_e, gsr_wr_en, gsr_wr_align, vis_dp_rd_data, wb_vis_ready,
        output vis_ctl_ready, vis_gsr_align, dp_vis_rs1, dp_vis_rs2,
               ctl_vis_sel_add, ctl_vis_sel_log, ctl_vis_sel_align,
               ctl_vis_add32, ctl_vis_subtract, ctl_vis_cin,
               ctl_vis_align0, ctl_vis_align2, ctl_vis_align4, ctl_vis_align6, ctl_vis_align_odd,
               ctl_vis_log_sel_nor, ctl_vis_log_sel_nand, ctl_vis_log_sel_xor, ctl_vis_log_sel_pass,
               ctl_vis_log_invert_rs1, ctl_vis_log_invert_rs2, ctl_vis_log_constant,
               ctl_vis_log_pass_const, ctl_vis_log_pass_rs1, ctl_vis_log_pass_rs2,
               vis_wb_valid, vis_wb_data, vis_wb_tid, vis_wb_rd, vis_wb_illegal
    );

    modport master (
        output ctl_vis_valid, ctl_vis_opf, ctl_vis_tid, ctl_vis_rd, frf_vis_rs1, frf_vis_rs2,
               ctl_vis_kill_e, gsr_wr_en, gsr_wr_align, vis_dp_rd_data, wb_vis_ready,
        input  vis_ctl_ready, vis_gsr_align, dp_vis_rs1, dp_vis_rs2,
               ctl_vis_sel_add, ctl_vis_sel_log, ctl_vis_sel_align,
               ctl_vis_add32, ctl_vis_subtract, ctl_vis_cin,
               ctl_vis_align0, ctl_vis_align2, ctl_vis_align4, ctl_vis_align6, ctl_vis_align_odd,
               ctl_vis_log_sel_nor, ctl_vis_log_sel_nand, ctl_vis_log_sel_xor, ctl_vis_log_sel_pass,
               ctl_vis_log_invert_rs1, ctl_vis_log_invert_rs2, ctl_vis_log_constant,
               ctl_vis_log_pass_const, ctl_vis_log_pass_rs1, ctl_vis_log_pass_rs2,
               vis_wb_valid, vis_wb_data, vis_wb_tid, vis_wb_rd, vis_wb_illegal
    );
endinterface

// File: rtl/sparc_ffu_vis_issue.sv
// VIS issue/writeback: E stage latches operands and one-hot decoded controls, W holds the result.
// Latency accept->wb_valid 2 cycles; ready = ~valid_e | (~valid_w | wb_ready), W and E hold under stall.
module sparc_ffu_vis_issue #(
    parameter int DW   = 64,
    parameter int TIDW = 2
) (
    input logic                  rclk,
    input logic                  arst_l,
    sparc_ffu_vis_issue_if.slave vis
);
    typedef struct packed {
        logic sel_add, sel_log, sel_align;
        logic add32, subtract, cin;
        logic align0, align2, align4, align6, align_odd;
        logic log_nor, log_nand, log_xor, log_pass;
        logic inv_rs1, inv_rs2, constant, pass_const, pass_rs1, pass_rs2;
    } ctl_t;

    logic            valid_e_q, valid_e_d, valid_w_q, valid_w_d, illegal_q;
    ctl_t            ctl_e_q, ctl_e_d, dec;
    logic            legal;
    logic [2:0]      gsr_q, align_src;
    logic [DW-1:0]   rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, data_w_q, data_w_d;
    logic [TIDW-1:0] tid_e_q, tid_e_d, tid_w_q, tid_w_d;
    logic [4:0]      rd_e_q, rd_e_d, rd_w_q, rd_w_d;
    logic            adv_w, accept, e_to_w;

    assign adv_w  = ~valid_w_q | vis.wb_vis_ready;
    assign accept = vis.ctl_vis_valid & vis.vis_ctl_ready;
    assign e_to_w = valid_e_q & adv_w & ~vis.ctl_vis_kill_e;
    // A GSR write in the accept cycle must be seen by the op being accepted.
    assign align_src = vis.gsr_wr_en ? vis.gsr_wr_align : gsr_q;

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        if (vis.ctl_vis_opf[8:3] == 6'b001010) begin
            legal        = 1'b1;
            dec.sel_add  = 1'b1;
            dec.subtract = vis.ctl_vis_opf[2];
            dec.cin      = vis.ctl_vis_opf[2];
            dec.add32    = vis.ctl_vis_opf[1];
        end else if (vis.ctl_vis_opf == 9'h048) begin
            legal         = 1'b1;
            dec.sel_align = 1'b1;
            dec.align0    = (align_src[2:1] == 2'd0);
            dec.align2    = (align_src[2:1] == 2'd1);
            dec.align4    = (align_src[2:1] == 2'd2);
            dec.align6    = (align_src[2:1] == 2'd3);
            dec.align_odd = align_src[0];
        end else if (vis.ctl_vis_opf[8:5] == 4'b0011) begin
            legal       = 1'b1;
            dec.sel_log = 1'b1;
            // AND/OR families are built from NOR/NAND with inverted inputs.
            case (vis.ctl_vis_opf[4:1])
                4'h0: begin dec.log_pass = 1'b1; dec.pass_const = 1'b1; end
                4'h1: dec.log_nor = 1'b1;
                4'h2: begin dec.log_nor = 1'b1; dec.inv_rs1 = 1'b1; end
                4'h3: begin dec.log_pass = 1'b1; dec.pass_rs2 = 1'b1; dec.inv_rs2 = 1'b1; end
                4'h4: begin dec.log_nor = 1'b1; dec.inv_rs2 = 1'b1; end
                4'h5: begin dec.log_pass = 1'b1; dec.pass_rs1 = 1'b1; dec.inv_rs1 = 1'b1; end
                4'h6: dec.log_xor = 1'b1;
                4'h7: dec.log_nand = 1'b1;
                4'h8: begin dec.log_nor = 1'b1; dec.inv_rs1 = 1'b1; dec.inv_rs2 = 1'b1; end
                4'h9: begin dec.log_xor = 1'b1; dec.inv_rs1 = 1'b1; end
                4'hA: begin dec.log_pass = 1'b1; dec.pass_rs1 = 1'b1; end
                4'hB: begin dec.log_nand = 1'b1; dec.inv_rs1 = 1'b1; end
                4'hC: begin dec.log_pass = 1'b1; dec.pass_rs2 = 1'b1; end
                4'hD: begin dec.log_nand = 1'b1; dec.inv_rs2 = 1'b1; end
                4'hE: begin dec.log_nand = 1'b1; dec.inv_rs1 = 1'b1; dec.inv_rs2 = 1'b1; end
                4'hF: begin dec.log_pass = 1'b1; dec.pass_const = 1'b1; dec.constant = 1'b1; end
            endcase
        end
    end

    always_comb begin
        valid_e_d = valid_e_q;
        ctl_e_d   = ctl_e_q;
        rs1_e_d   = rs1_e_q;
        rs2_e_d   = rs2_e_q;
        tid_e_d   = tid_e_q;
        rd_e_d    = rd_e_q;
        if (accept) begin
            valid_e_d = legal;
            ctl_e_d   = legal ? dec : '0;
            rs1_e_d   = vis.frf_vis_rs1;
            rs2_e_d   = vis.frf_vis_rs2;
            tid_e_d   = vis.ctl_vis_tid;
            rd_e_d    = vis.ctl_vis_rd;
        end else if (valid_e_q && (adv_w || vis.ctl_vis_kill_e)) begin
            valid_e_d = 1'b0;
            ctl_e_d   = '0;
        end
        valid_w_d = valid_w_q;
        data_w_d  = data_w_q;
        tid_w_d   = tid_w_q;
        rd_w_d    = rd_w_q;
        if (e_to_w) begin
            valid_w_d = 1'b1;
            data_w_d  = vis.vis_dp_rd_data;
            tid_w_d   = tid_e_q;
            rd_w_d    = rd_e_q;
        end else if (adv_w) begin
            valid_w_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            valid_e_q <= 1'b0;
            valid_w_q <= 1'b0;
            illegal_q <= 1'b0;
            ctl_e_q   <= '0;
            gsr_q     <= '0;
            rs1_e_q   <= '0;
            rs2_e_q   <= '0;
            tid_e_q   <= '0;
            rd_e_q    <= '0;
            data_w_q  <= '0;
            tid_w_q   <= '0;
            rd_w_q    <= '0;
        end else begin
            valid_e_q <= valid_e_d;
            valid_w_q <= valid_w_d;
            illegal_q <= accept & ~legal;
            ctl_e_q   <= ctl_e_d;
            gsr_q     <= align_src;
            rs1_e_q   <= rs1_e_d;
            rs2_e_q   <= rs2_e_d;
            tid_e_q   <= tid_e_d;
            rd_e_q    <= rd_e_d;
            data_w_q  <= data_w_d;
            tid_w_q   <= tid_w_d;
            rd_w_q    <= rd_w_d;
        end
    end

    assign vis.vis_ctl_ready          = ~valid_e_q | adv_w;
    assign vis.vis_gsr_align          = gsr_q;
    assign vis.dp_vis_rs1             = rs1_e_q;
    assign vis.dp_vis_rs2             = rs2_e_q;
    assign vis.ctl_vis_sel_add        = ctl_e_q.sel_add;
    assign vis.ctl_vis_sel_log        = ctl_e_q.sel_log;
    assign vis.ctl_vis_sel_align      = ctl_e_q.sel_align;
    assign vis.ctl_vis_add32          = ctl_e_q.add32;
    assign vis.ctl_vis_subtract       = ctl_e_q.subtract;
    assign vis.ctl_vis_cin            = ctl_e_q.cin;
    assign vis.ctl_vis_align0         = ctl_e_q.align0;
    assign vis.ctl_vis_align2         = ctl_e_q.align2;
    assign vis.ctl_vis_align4         = ctl_e_q.align4;
    assign vis.ctl_vis_align6         = ctl_e_q.align6;
    assign vis.ctl_vis_align_odd      = ctl_e_q.align_odd;
    assign vis.ctl_vis_log_sel_nor    = ctl_e_q.log_nor;
    assign vis.ctl_vis_log_sel_nand   = ctl_e_q.log_nand;
    assign vis.ctl_vis_log_sel_xor    = ctl_e_q.log_xor;
    assign vis.ctl_vis_log_sel_pass   = ctl_e_q.log_pass;
    assign vis.ctl_vis_log_invert_rs1 = ctl_e_q.inv_rs1;
    assign vis.ctl_vis_log_invert_rs2 = ctl_e_q.inv_rs2;
    assign vis.ctl_vis_log_constant   = ctl_e_q.constant;
    assign vis.ctl_vis_log_pass_const = ctl_e_q.pass_const;
    assign vis.ctl_vis_log_pass_rs1   = ctl_e_q.pass_rs1;
    assign vis.ctl_vis_log_pass_rs2   = ctl_e_q.pass_rs2;
    assign vis.vis_wb_valid           = valid_w_q;
    assign vis.vis_wb_data            = data_w_q;
    assign vis.vis_wb_tid             = tid_w_q;
    assign vis.vis_wb_rd              = rd_w_q;
    assign vis.vis_wb_illegal         = illegal_q;
endmodule
